// File: rtl/adam_gpio_debounce.sv
// Per-channel two-flop synchroniser plus stability-counter debouncer for raw board inputs.
// Optional registered rise/fall pulses are built only when ADAM_DEBOUNCE_EDGE_EN is defined.
module adam_gpio_debounce #(
  parameter int WIDTH           = 8,
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  generate
    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1))) begin : g_bad_cfg
      $error("adam_gpio_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end
  endgenerate

  // Count value on which the pending level is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync0_reg;
  logic [WIDTH-1:0] sync1_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_reg <= '0;
      sync1_reg <= '0;
    end else begin
      sync0_reg <= pad_i;
      sync1_reg <= sync0_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 level_reg;
      logic                 level_next;

      // Any sample matching the accepted level restarts the stability window.
      always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync1_reg[gi] != level_reg) begin
          if (cnt_reg == CNT_LAST) begin
            level_next = sync1_reg[gi];
          end else begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
        end
      end

      assign gpio_o[gi] = level_reg;

`ifdef ADAM_DEBOUNCE_EDGE_EN
      logic rise_reg;
      logic fall_reg;

      // Pulses are registered alongside the level so they coincide with the gpio_o change.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= level_next & ~level_reg;
          fall_reg <= ~level_next & level_reg;
        end
      end

      assign rise_o[gi] = rise_reg;
      assign fall_o[gi] = fall_reg;
`else
      assign rise_o[gi] = 1'b0;
      assign fall_o[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_adam_gpio_debounce.sv
// Directed bench for adam_gpio_debounce with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_adam_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pad = 8'h00;
  logic [7:0] gpio;
  logic [7:0] rise;
  logic [7:0] fall;

  int checks   = 0;
  int failures = 0;

`ifdef ADAM_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  adam_gpio_debounce #(
    .WIDTH(8),
    .CNT_WIDTH(20),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pad_i (pad),
    .gpio_o(gpio),
    .rise_o(rise),
    .fall_o(fall)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ep(input logic [7:0] x);
    return EDGE ? x : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] eg, input logic [7:0] er,
                      input logic [7:0] ef);
    chk({tag, ".gpio"}, gpio, eg);
    chk({tag, ".rise"}, rise, er);
    chk({tag, ".fall"}, fall, ef);
    $display("step %s gpio=%h rise=%h fall=%h", tag, gpio, rise, fall);
  endtask

  initial begin
    logic [7:0] bounce [0:4];

    // Reset, then idle low.
    rst = 1'b1; pad = 8'h00;
    tick(); tick();
    chk3("reset", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk3($sformatf("idle%0d", k), 8'h00, 8'h00, 8'h00);
    end

    // Bit 0 rises: sampled at edge 1, accepted at edge 6.
    pad = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk3($sformatf("b0_e%0d", k), 8'h00, 8'h00, 8'h00);
    end
    tick();
    chk3("b0_e6", 8'h01, ep(8'h01), 8'h00);
    tick();
    chk3("b0_e7", 8'h01, 8'h00, 8'h00);

    // Bit 3 glitch of 3 cycles is rejected.
    pad = 8'h09;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk3($sformatf("gl3_e%0d", k), 8'h01, 8'h00, 8'h00);
    end
    pad = 8'h01;
    for (int k = 4; k <= 12; k++) begin
      tick();
      chk3($sformatf("gl3_e%0d", k), 8'h01, 8'h00, 8'h00);
    end

    // Bit 3 pulse of 5 cycles: rise at edge 6, fall at edge 11.
    pad = 8'h09;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk3($sformatf("p5_e%0d", k), 8'h01, 8'h00, 8'h00);
    end
    pad = 8'h01;
    tick();
    chk3("p5_e6", 8'h09, ep(8'h08), 8'h00);
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk3($sformatf("p5_e%0d", k), 8'h09, 8'h00, 8'h00);
    end
    tick();
    chk3("p5_e11", 8'h01, 8'h00, ep(8'h08));
    tick();
    chk3("p5_e12", 8'h01, 8'h00, 8'h00);

    // Bit 5 bounces 1,0,1,0,1 then holds: one accept at edge 10.
    bounce[0] = 8'h21; bounce[1] = 8'h01; bounce[2] = 8'h21;
    bounce[3] = 8'h01; bounce[4] = 8'h21;
    for (int k = 1; k <= 5; k++) begin
      pad = bounce[k-1];
      tick();
      chk3($sformatf("bn_e%0d", k), 8'h01, 8'h00, 8'h00);
    end
    pad = 8'h21;
    for (int k = 6; k <= 9; k++) begin
      tick();
      chk3($sformatf("bn_e%0d", k), 8'h01, 8'h00, 8'h00);
    end
    tick();
    chk3("bn_e10", 8'h21, ep(8'h20), 8'h00);
    for (int k = 11; k <= 13; k++) begin
      tick();
      chk3($sformatf("bn_e%0d", k), 8'h21, 8'h00, 8'h00);
    end

    // All bits high at once, bit 7 drops after 2 cycles and is rejected.
    pad = 8'hFF;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk3($sformatf("all_e%0d", k), 8'h21, 8'h00, 8'h00);
    end
    pad = 8'h7F;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk3($sformatf("all_e%0d", k), 8'h21, 8'h00, 8'h00);
    end
    tick();
    chk3("all_e6", 8'h7F, ep(8'h5E), 8'h00);
    for (int k = 7; k <= 10; k++) begin
      tick();
      chk3($sformatf("all_e%0d", k), 8'h7F, 8'h00, 8'h00);
    end

    // Reset mid-count on bit 2 discards the pending accept.
    rst = 1'b1; pad = 8'h00;
    tick(); tick();
    chk3("rst2_a", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    pad = 8'h04;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk3($sformatf("rs_e%0d", k), 8'h00, 8'h00, 8'h00);
    end
    rst = 1'b1;
    tick();
    chk3("rs_e5", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      tick();
      chk3($sformatf("rs_e%0d", k), 8'h00, 8'h00, 8'h00);
    end
    tick();
    chk3("rs_e11", 8'h04, ep(8'h04), 8'h00);
    tick();
    chk3("rs_e12", 8'h04, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
